// File: rtl/control_pkg.sv
// Shared definitions for the registered, hazard-aware control stage.
// Holds opcode/funct values, ALU select encodings, control bundle bit
// offsets and the issue FSM state type. The optional forwarding build is
// selected with the CONTROL_FWD_EN macro in the files that import this package.
package control_pkg;

  localparam logic [5:0] OP_LW    = 6'd34;
  localparam logic [5:0] OP_SW    = 6'd35;
  localparam logic [5:0] OP_BNE   = 6'd36;
  localparam logic [5:0] OP_ADDI  = 6'd37;
  localparam logic [5:0] OP_ORI   = 6'd38;
  localparam logic [5:0] OP_JMP   = 6'd2;
  localparam logic [5:0] OP_RTYPE = 6'd12;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_MUL = 6'd50;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Bundle layout, LSB first:
  // jmpFlag, branchFlag, CS_WB_2, WR_mem, mux2_ALU, mul_Start, ALU_sel[1:0],
  // mux_immediate_or_regB, WR_regfile, rd, rt, rs
  localparam int BIT_JMP       = 0;
  localparam int BIT_BRANCH    = 1;
  localparam int BIT_CS_WB2    = 2;
  localparam int BIT_WR_MEM    = 3;
  localparam int BIT_MUX2_ALU  = 4;
  localparam int BIT_MUL_START = 5;
  localparam int BIT_ALU_LO    = 6;
  localparam int BIT_MUX_IMM   = 8;
  localparam int BIT_WR_REG    = 9;
  localparam int BIT_RD_LO     = 10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_BUSY = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/control_decode.sv
// Purely combinational instruction decoder: 32-bit word in, control bundle
// and hazard-relevant attributes out. Undefined opcodes/functs produce the
// NOP bundle (only mux2_ALU set) and raise o_illegal. The o_isLoad output
// exists only when CONTROL_FWD_EN is defined.
module control_decode
  import control_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int CTRL_W = 3*REG_W+10
) (
  input  logic [31:0]       i_instr,
  output logic [CTRL_W-1:0] o_bundle,
  output logic              o_usesRs,
  output logic              o_usesRt,
  output logic              o_isWriter,
`ifdef CONTROL_FWD_EN
  output logic              o_isLoad,
`endif
  output logic              o_isMul,
  output logic              o_illegal
);

  logic [5:0]       w_opcode;
  logic [5:0]       w_funct;
  logic [REG_W-1:0] w_rs;
  logic [REG_W-1:0] w_rt;
  logic [REG_W-1:0] w_rd;
  logic [1:0]       w_aluSel;
  logic             w_wrReg;
  logic             w_muxImm;
  logic             w_mulStart;
  logic             w_mux2Alu;
  logic             w_wrMem;
  logic             w_csWb2;
  logic             w_branch;
  logic             w_jmp;
  logic             w_unusedShamt;

  assign w_opcode      = i_instr[31:26];
  assign w_funct       = i_instr[5:0];
  // The shamt field has no meaning for this instruction set.
  assign w_unusedShamt = ^i_instr[10:6];

  // Decode opcode/funct into control fields and source/destination usage.
  always_comb begin
    w_rs       = REG_W'(i_instr[25:21]);
    w_rt       = REG_W'(i_instr[20:16]);
    w_rd       = '0;
    w_aluSel   = ALU_ADD;
    w_wrReg    = 1'b0;
    w_muxImm   = 1'b0;
    w_mulStart = 1'b0;
    w_mux2Alu  = 1'b1;
    w_wrMem    = 1'b0;
    w_csWb2    = 1'b0;
    w_branch   = 1'b0;
    w_jmp      = 1'b0;
    o_usesRs   = 1'b0;
    o_usesRt   = 1'b0;
    o_isWriter = 1'b0;
    o_isMul    = 1'b0;
    o_illegal  = 1'b0;
    case (w_opcode)
      OP_LW: begin
        w_wrReg = 1'b1; w_muxImm = 1'b1; w_csWb2 = 1'b1;
        w_rd = w_rt; o_usesRs = 1'b1; o_isWriter = 1'b1;
      end
      OP_SW: begin
        w_wrMem = 1'b1; w_muxImm = 1'b1;
        o_usesRs = 1'b1; o_usesRt = 1'b1;
      end
      OP_BNE: begin
        w_aluSel = ALU_SUB; w_branch = 1'b1;
        o_usesRs = 1'b1; o_usesRt = 1'b1;
      end
      OP_ADDI: begin
        w_wrReg = 1'b1; w_muxImm = 1'b1;
        w_rd = w_rt; o_usesRs = 1'b1; o_isWriter = 1'b1;
      end
      OP_ORI: begin
        w_aluSel = ALU_OR; w_wrReg = 1'b1; w_muxImm = 1'b1;
        w_rd = w_rt; o_usesRs = 1'b1; o_isWriter = 1'b1;
      end
      OP_JMP: w_jmp = 1'b1;
      OP_RTYPE: begin
        w_rd = REG_W'(i_instr[15:11]);
        w_wrReg = 1'b1; o_usesRs = 1'b1; o_usesRt = 1'b1; o_isWriter = 1'b1;
        case (w_funct)
          FN_ADD: w_aluSel = ALU_ADD;
          FN_SUB: w_aluSel = ALU_SUB;
          FN_MUL: begin
            w_mux2Alu = 1'b0; w_mulStart = 1'b1; o_isMul = 1'b1;
          end
          default: o_illegal = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
    if (o_illegal) begin
      w_rs = '0; w_rt = '0; w_rd = '0; w_aluSel = ALU_ADD;
      w_wrReg = 1'b0; w_mulStart = 1'b0; w_mux2Alu = 1'b1;
      o_usesRs = 1'b0; o_usesRt = 1'b0; o_isWriter = 1'b0; o_isMul = 1'b0;
    end
  end

  assign o_bundle = {w_rs, w_rt, w_rd, w_wrReg, w_muxImm, w_aluSel, w_mulStart,
                     w_mux2Alu, w_wrMem, w_csWb2, w_branch, w_jmp};

`ifdef CONTROL_FWD_EN
  assign o_isLoad = w_csWb2;
`endif

endmodule

// File: rtl/control_pipe.sv
// Registered control stage: valid/ready intake from fetch, decode, and a
// one-cycle registered issue of the control bundle to execute. Adds RAW
// stalling against a write-back scoreboard, multiplier occupancy and
// post-jump/taken-branch squashing. Defining CONTROL_FWD_EN lets ALU results
// forward (fwd_a/fwd_b ports) so only load and mul results stall.
module control_pipe
  import control_pkg::*;
#(
  parameter  int REG_W       = 5,
  parameter  int MUL_LATENCY = 4,
  parameter  int SB_DEPTH    = 3,
  parameter  int FLUSH_SLOTS = 1,
  localparam int CTRL_W      = 3*REG_W+10,
  localparam int FWD_W       = $clog2(SB_DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  input  logic              br_taken,
  output logic              ctrl_valid,
  output logic [CTRL_W-1:0] ctrl_bus,
  output logic              stall,
  output logic              illegal
`ifdef CONTROL_FWD_EN
  ,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b
`endif
);

  localparam int MUL_CNT_W = $clog2(MUL_LATENCY+1);
  localparam int FLUSH_W   = 2;

  logic [CTRL_W-1:0]    w_decBundle;
  logic                 w_decUsesRs;
  logic                 w_decUsesRt;
  logic                 w_decWriter;
  logic                 w_decMul;
  logic                 w_decIllegal;
  logic [REG_W-1:0]     w_rs;
  logic [REG_W-1:0]     w_rt;
  logic [REG_W-1:0]     w_rd;
  logic                 w_srcRsLive;
  logic                 w_srcRtLive;
  logic                 w_hazard;
  logic                 w_flushing;
  logic                 w_accept;
  logic                 w_issue;
  logic                 w_mulBusy;
  ctrl_state_e          r_state;
  ctrl_state_e          w_nextState;
  logic [MUL_CNT_W-1:0] r_mulCnt;
  logic [FLUSH_W-1:0]   r_flushCnt;
  logic                 r_sbValid [SB_DEPTH];
  logic [REG_W-1:0]     r_sbDest  [SB_DEPTH];
  logic                 r_ctrlValid;
  logic [CTRL_W-1:0]    r_ctrlBus;
  logic                 r_illegal;
`ifdef CONTROL_FWD_EN
  logic                 w_decLoad;
  logic                 r_sbLoad  [SB_DEPTH];
  logic                 r_sbMul   [SB_DEPTH];
  logic                 w_stallA;
  logic                 w_stallB;
  logic [FWD_W-1:0]     w_fwdA;
  logic [FWD_W-1:0]     w_fwdB;
  logic [FWD_W-1:0]     r_fwdA;
  logic [FWD_W-1:0]     r_fwdB;
`endif

  control_decode #(.REG_W(REG_W), .CTRL_W(CTRL_W)) u_decode (
    .i_instr    (instr),
    .o_bundle   (w_decBundle),
    .o_usesRs   (w_decUsesRs),
    .o_usesRt   (w_decUsesRt),
    .o_isWriter (w_decWriter),
`ifdef CONTROL_FWD_EN
    .o_isLoad   (w_decLoad),
`endif
    .o_isMul    (w_decMul),
    .o_illegal  (w_decIllegal)
  );

  assign w_rs        = w_decBundle[BIT_RD_LO+2*REG_W +: REG_W];
  assign w_rt        = w_decBundle[BIT_RD_LO+REG_W +: REG_W];
  assign w_rd        = w_decBundle[BIT_RD_LO +: REG_W];
  assign w_srcRsLive = w_decUsesRs && (w_rs != '0);
  assign w_srcRtLive = w_decUsesRt && (w_rt != '0);

  // Compare live sources against in-flight writers; the youngest match decides.
  always_comb begin
    w_hazard = 1'b0;
`ifdef CONTROL_FWD_EN
    w_stallA = 1'b0;
    w_stallB = 1'b0;
    w_fwdA   = '0;
    w_fwdB   = '0;
    for (int i = SB_DEPTH-1; i >= 0; i--) begin
      if (r_sbValid[i] && w_srcRsLive && (r_sbDest[i] == w_rs)) begin
        w_stallA = r_sbLoad[i] || r_sbMul[i];
        w_fwdA   = w_stallA ? '0 : FWD_W'(i+1);
      end
      if (r_sbValid[i] && w_srcRtLive && (r_sbDest[i] == w_rt)) begin
        w_stallB = r_sbLoad[i] || r_sbMul[i];
        w_fwdB   = w_stallB ? '0 : FWD_W'(i+1);
      end
    end
    w_hazard = w_stallA || w_stallB;
`else
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (r_sbValid[i] && ((w_srcRsLive && (r_sbDest[i] == w_rs)) ||
                           (w_srcRtLive && (r_sbDest[i] == w_rt))))
        w_hazard = 1'b1;
    end
`endif
  end

  assign w_flushing  = (r_flushCnt != '0);
  assign stall       = w_mulBusy || (instr_valid && w_hazard && !w_flushing);
  assign instr_ready = !stall;
  assign w_accept    = instr_valid && instr_ready;
  assign w_issue     = w_accept && !w_flushing;

  // Issue FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_nextState;
  end

  // Next state: enter MUL_BUSY on an issued mul, leave when the count expires.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_RUN:      if (w_issue && w_decMul) w_nextState = ST_MUL_BUSY;
      ST_MUL_BUSY: if (r_mulCnt == MUL_CNT_W'(1)) w_nextState = ST_RUN;
      default:     w_nextState = ST_RUN;
    endcase
  end

  // FSM output: the multiplier blocks issue while busy.
  always_comb begin
    w_mulBusy = (r_state == ST_MUL_BUSY);
  end

  // Multiplier occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_mulCnt <= '0;
    else if ((r_state == ST_RUN) && w_issue && w_decMul)
      r_mulCnt <= MUL_CNT_W'(MUL_LATENCY);
    else if (r_state == ST_MUL_BUSY)
      r_mulCnt <= r_mulCnt - MUL_CNT_W'(1);
  end

  // Flush slot counter: loaded by jmp issue or taken branch, spent per accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_flushCnt <= '0;
    else if (br_taken || (w_issue && w_decBundle[BIT_JMP]))
      r_flushCnt <= FLUSH_W'(FLUSH_SLOTS);
    else if (w_accept && w_flushing)
      r_flushCnt <= r_flushCnt - FLUSH_W'(1);
  end

  // Write-back scoreboard shifts every cycle; only issued writers enter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        r_sbValid[i] <= 1'b0;
        r_sbDest[i]  <= '0;
`ifdef CONTROL_FWD_EN
        r_sbLoad[i]  <= 1'b0;
        r_sbMul[i]   <= 1'b0;
`endif
      end
    end else begin
      r_sbValid[0] <= w_issue && w_decWriter;
      r_sbDest[0]  <= (w_issue && w_decWriter) ? w_rd : '0;
`ifdef CONTROL_FWD_EN
      r_sbLoad[0]  <= w_issue && w_decWriter && w_decLoad;
      r_sbMul[0]   <= w_issue && w_decWriter && w_decMul;
`endif
      for (int i = 1; i < SB_DEPTH; i++) begin
        r_sbValid[i] <= r_sbValid[i-1];
        r_sbDest[i]  <= r_sbDest[i-1];
`ifdef CONTROL_FWD_EN
        r_sbLoad[i]  <= r_sbLoad[i-1];
        r_sbMul[i]   <= r_sbMul[i-1];
`endif
      end
    end
  end

  // Registered issue to execute; squashed or absent words become bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrlValid <= 1'b0;
      r_ctrlBus   <= '0;
      r_illegal   <= 1'b0;
`ifdef CONTROL_FWD_EN
      r_fwdA      <= '0;
      r_fwdB      <= '0;
`endif
    end else begin
      r_ctrlValid <= w_issue;
      r_ctrlBus   <= w_issue ? w_decBundle : '0;
      r_illegal   <= w_issue && w_decIllegal;
`ifdef CONTROL_FWD_EN
      r_fwdA      <= w_issue ? w_fwdA : '0;
      r_fwdB      <= w_issue ? w_fwdB : '0;
`endif
    end
  end

  assign ctrl_valid = r_ctrlValid;
  assign ctrl_bus   = r_ctrlBus;
  assign illegal    = r_illegal;
`ifdef CONTROL_FWD_EN
  assign fwd_a      = r_fwdA;
  assign fwd_b      = r_fwdB;
`endif

endmodule
